// File: rtl/camera_debug_pkg.sv
// Shared pixel type, default panel colours and the cell-bit index helper
// used by the camera debug overlay.
package camera_debug_pkg;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t DEF_COLOR_ON   = 12'h00F;
  localparam rgb12_t DEF_COLOR_OFF  = 12'h000;
  localparam rgb12_t DEF_COLOR_LINE = 12'h444;
  localparam rgb12_t DEF_COLOR_BG   = 12'hFFF;

  // Mask bit for a cell: row-major, row*cols + col.
  function automatic int cell_bit(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/camera_debug_overlay_pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear; keeps the
// pixel sideband aligned with framebuffer read data.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/camera_debug_overlay.sv
// Camera preview plus GRID_COLS x GRID_ROWS vision-cell panel renderer.
// Every pixel path takes MEM_LATENCY+1 cycles from timing inputs to rgb_out.
module camera_debug_overlay
  import camera_debug_pkg::*;
#(
  parameter int     FRAME_W     = 320,
  parameter int     FRAME_H     = 240,
  parameter int     GRID_COLS   = 3,
  parameter int     GRID_ROWS   = 3,
  parameter int     MEM_LATENCY = 2,
  parameter rgb12_t COLOR_ON    = DEF_COLOR_ON,
  parameter rgb12_t COLOR_OFF   = DEF_COLOR_OFF,
  parameter rgb12_t COLOR_LINE  = DEF_COLOR_LINE,
  parameter rgb12_t COLOR_BG    = DEF_COLOR_BG
) (
  input  logic                                 system_clock_in,
  input  logic                                 reset_n_in,
  input  logic [10:0]                          hcount_in,
  input  logic [9:0]                           vcount_in,
  input  logic                                 hsync_in,
  input  logic                                 vsync_in,
  input  logic                                 blank_in,
  input  logic [GRID_COLS*GRID_ROWS-1:0]       grid_mask_in,
  input  logic                                 mask_valid_in,
  input  logic                                 show_grid_lines_in,
  output logic [$clog2(FRAME_W*FRAME_H)-1:0]   fb_addr_out,
  input  logic [11:0]                          fb_data_in,
  output rgb12_t                               rgb_out,
  output logic                                 hsync_out,
  output logic                                 vsync_out,
  output logic                                 blank_out
);

  localparam int AW    = $clog2(FRAME_W*FRAME_H);
  localparam int NCELL = GRID_COLS * GRID_ROWS;
  localparam int CW    = FRAME_W / GRID_COLS;
  localparam int RH    = FRAME_H / GRID_ROWS;
  localparam int CPW   = (CW > 1) ? $clog2(CW) : 1;
  localparam int RPW   = (RH > 1) ? $clog2(RH) : 1;
  localparam int CIW   = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int RIW   = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int BW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int PW    = BW + 6;

  logic              w_in_prev, w_in_grid, w_frame_start;
  logic [AW-1:0]     w_addr;

  logic [AW-1:0]     r_addr;
  logic              r_vis, r_hs, r_vs, r_prev, r_grid, r_show;
  logic [CPW-1:0]    r_col_pos;
  logic [CIW-1:0]    r_col_idx;
  logic [RPW-1:0]    r_row_pos;
  logic [RIW-1:0]    r_row_idx;
  logic [NCELL-1:0]  r_pending_mask, r_active_mask;
  logic              r_pending;

  logic              w_line;
  logic [BW-1:0]     w_cell;
  logic [PW-1:0]     w_s0, w_sn;
  logic              w_d_vis, w_d_hs, w_d_vs, w_d_prev, w_d_grid, w_d_line;
  logic [BW-1:0]     w_d_cell;

  assign w_in_prev     = (hcount_in < 11'(FRAME_W)) && (vcount_in < 10'(FRAME_H));
  assign w_in_grid     = (hcount_in >= 11'(FRAME_W)) && (hcount_in < 11'(2*FRAME_W)) &&
                         (vcount_in < 10'(FRAME_H));
  assign w_frame_start = (hcount_in == '0) && (vcount_in == '0);
  assign w_addr        = AW'(vcount_in) * AW'(FRAME_W) + AW'(hcount_in);

  // Stage 0: address and region/timing capture. Blank is carried inverted so a
  // cleared pipeline reads as blanked.
  always_ff @(posedge system_clock_in) begin
    if (!reset_n_in) begin
      r_addr <= '0;
      r_vis  <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_prev <= 1'b0;
      r_grid <= 1'b0;
      r_show <= 1'b0;
    end else begin
      r_addr <= w_in_prev ? w_addr : '0;
      r_vis  <= ~blank_in;
      r_hs   <= hsync_in;
      r_vs   <= vsync_in;
      r_prev <= w_in_prev;
      r_grid <= w_in_grid;
      r_show <= show_grid_lines_in;
    end
  end

  // Running column counter; the last column absorbs the width remainder.
  always_ff @(posedge system_clock_in) begin
    if (!reset_n_in || hcount_in == 11'(FRAME_W)) begin
      r_col_pos <= '0;
      r_col_idx <= '0;
    end else if (r_col_pos == CPW'(CW-1)) begin
      r_col_pos <= '0;
      if (r_col_idx != CIW'(GRID_COLS-1)) r_col_idx <= r_col_idx + 1'b1;
    end else begin
      r_col_pos <= r_col_pos + 1'b1;
    end
  end

  always_ff @(posedge system_clock_in) begin
    if (!reset_n_in || vcount_in == '0) begin
      r_row_pos <= '0;
      r_row_idx <= '0;
    end else if (hcount_in == '0) begin
      if (r_row_pos == RPW'(RH-1)) begin
        r_row_pos <= '0;
        if (r_row_idx != RIW'(GRID_ROWS-1)) r_row_idx <= r_row_idx + 1'b1;
      end else begin
        r_row_pos <= r_row_pos + 1'b1;
      end
    end
  end

  // A strobe coinciding with frame start stays pending: the swap uses the old value.
  always_ff @(posedge system_clock_in) begin
    if (!reset_n_in) begin
      r_pending_mask <= '0;
      r_active_mask  <= '0;
      r_pending      <= 1'b0;
    end else begin
      if (w_frame_start && r_pending) begin
        r_active_mask <= r_pending_mask;
        r_pending     <= 1'b0;
      end
      if (mask_valid_in) begin
        r_pending_mask <= grid_mask_in;
        r_pending      <= 1'b1;
      end
    end
  end

  assign w_line = r_show && r_grid &&
                  ((r_col_pos == '0 && r_col_idx != '0) ||
                   (r_row_pos == '0 && r_row_idx != '0));
  assign w_cell = BW'(cell_bit(int'(r_row_idx), int'(r_col_idx), GRID_COLS));
  assign w_s0   = {r_vis, r_hs, r_vs, r_prev, r_grid, w_line, w_cell};

  pipe_delay #(
    .WIDTH (PW),
    .DEPTH (MEM_LATENCY)
  ) u_side (
    .i_clk   (system_clock_in),
    .i_rst_n (reset_n_in),
    .i_d     (w_s0),
    .o_q     (w_sn)
  );

  assign {w_d_vis, w_d_hs, w_d_vs, w_d_prev, w_d_grid, w_d_line, w_d_cell} = w_sn;

  assign fb_addr_out = r_addr;
  assign hsync_out   = w_d_hs;
  assign vsync_out   = w_d_vs;
  assign blank_out   = ~w_d_vis;

  always_comb begin
    rgb_out = COLOR_BG;
    if (!w_d_vis)
      rgb_out = 12'h000;
    else if (w_d_prev)
      rgb_out = fb_data_in;
    else if (w_d_grid)
      rgb_out = w_d_line ? COLOR_LINE : (r_active_mask[w_d_cell] ? COLOR_ON : COLOR_OFF);
  end

endmodule

// File: tb/tb_camera_debug_overlay.sv
// Scoreboard bench for camera_debug_overlay: a raster driver pushes expected
// pixels from an arithmetic reference model; a monitor pops and compares.
module tb_camera_debug_overlay;

  localparam int FW   = 320;
  localparam int FH   = 240;
  localparam int COLS = 3;
  localparam int ROWS = 3;
  localparam int ML   = 2;
  localparam int L    = ML + 1;
  localparam int CW   = FW / COLS;
  localparam int RH   = FH / ROWS;
  localparam int NC   = COLS * ROWS;
  localparam int AW   = $clog2(FW*FH);
  localparam int VTOT = 245;
  localparam int HEND = 720;

  logic          clk = 1'b0;
  logic          reset_n_in = 1'b0;
  logic [10:0]   hcount_in = '0;
  logic [9:0]    vcount_in = '0;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b1;
  logic [NC-1:0] grid_mask_in = '0;
  logic          mask_valid_in = 1'b0, show_grid_lines_in = 1'b0;
  logic [AW-1:0] fb_addr_out;
  logic [11:0]   fb_data_in;
  logic [11:0]   rgb_out;
  logic          hsync_out, vsync_out, blank_out;

  always #5 clk = ~clk;

  camera_debug_overlay #(
    .FRAME_W(FW), .FRAME_H(FH), .GRID_COLS(COLS), .GRID_ROWS(ROWS), .MEM_LATENCY(ML)
  ) dut (
    .system_clock_in    (clk),
    .reset_n_in         (reset_n_in),
    .hcount_in          (hcount_in),
    .vcount_in          (vcount_in),
    .hsync_in           (hsync_in),
    .vsync_in           (vsync_in),
    .blank_in           (blank_in),
    .grid_mask_in       (grid_mask_in),
    .mask_valid_in      (mask_valid_in),
    .show_grid_lines_in (show_grid_lines_in),
    .fb_addr_out        (fb_addr_out),
    .fb_data_in         (fb_data_in),
    .rgb_out            (rgb_out),
    .hsync_out          (hsync_out),
    .vsync_out          (vsync_out),
    .blank_out          (blank_out)
  );

  // Framebuffer model: data = addr[11:0], ML cycles after the address.
  logic [11:0] mem_q [ML];
  always @(posedge clk) begin
    mem_q[0] <= fb_addr_out[11:0];
    for (int i = 1; i < ML; i++) mem_q[i] <= mem_q[i-1];
  end
  assign fb_data_in = mem_q[ML-1];

  typedef struct { int due; int h; int v; logic [11:0] rgb; logic hs; logic vs; logic bl; } oexp_t;
  typedef struct { int due; int h; int v; logic [AW-1:0] addr; } aexp_t;

  oexp_t oq[$];
  aexp_t aq[$];
  int    cyc = 0, n_tests = 0, n_fail = 0;

  logic [NC-1:0] m_active = '0, m_pmask = '0;
  bit            m_pend = 0, in_reset = 0, rand_strobe = 0;
  bit            full_ln [VTOT];

  always @(posedge clk) cyc++;

  function automatic logic [11:0] ref_pix(input int h, input int v, input bit bl,
                                          input bit show, input logic [NC-1:0] act);
    int off, col, row;
    bit ln;
    logic [31:0] a;
    if (bl) return 12'h000;
    if (h < FW && v < FH) begin
      a = 32'(v * FW + h);
      return a[11:0];
    end
    if (h >= FW && h < 2*FW && v < FH) begin
      off = h - FW;
      col = off / CW;  if (col > COLS-1) col = COLS-1;
      row = v / RH;    if (row > ROWS-1) row = ROWS-1;
      ln  = show && (((off % CW) == 0 && col != 0) || ((v % RH) == 0 && row != 0));
      if (ln) return 12'h444;
      return act[row*COLS + col] ? 12'h00F : 12'h000;
    end
    return 12'hFFF;
  endfunction

  task automatic step(input int h, input int v, input bit rst, input bit mv, input logic [NC-1:0] m);
    oexp_t oe;
    aexp_t ae;
    logic [31:0] a;
    @(negedge clk);
    reset_n_in         = ~rst;
    hcount_in          = 11'(h);
    vcount_in          = 10'(v);
    hsync_in           = 1'($urandom_range(0, 1));
    vsync_in           = 1'($urandom_range(0, 1));
    blank_in           = ($urandom_range(0, 15) == 0);
    show_grid_lines_in = 1'($urandom_range(0, 1));
    mask_valid_in      = mv & ~rst;
    grid_mask_in       = m;
    if (rst) begin
      // In-flight pixels are lost: reset values show from the next edge on.
      while (oq.size() > 0 && oq[$].due > cyc) oq.delete(oq.size()-1);
      while (aq.size() > 0 && aq[$].due > cyc) aq.delete(aq.size()-1);
      oe = '{cyc+1, h, v, 12'h000, 1'b0, 1'b0, 1'b1};
      ae = '{cyc+1, h, v, '0};
      oq.push_back(oe);
      aq.push_back(ae);
      m_active = '0; m_pmask = '0; m_pend = 0; in_reset = 1;
    end else begin
      if (in_reset)
        for (int k = 1; k < L; k++) begin
          oe = '{cyc+k, -1, -1, 12'h000, 1'b0, 1'b0, 1'b1};
          oq.push_back(oe);
        end
      in_reset = 0;
      if (h == 0 && v == 0 && m_pend) begin m_active = m_pmask; m_pend = 0; end
      if (mv) begin m_pmask = m; m_pend = 1; end
      a  = (h < FW && v < FH) ? 32'(v * FW + h) : 32'd0;
      ae = '{cyc+1, h, v, a[AW-1:0]};
      oe = '{cyc+L, h, v, ref_pix(h, v, blank_in, show_grid_lines_in, m_active),
             hsync_in, vsync_in, blank_in};
      aq.push_back(ae);
      oq.push_back(oe);
    end
  endtask

  task automatic clr_full();
    for (int i = 0; i < VTOT; i++) full_ln[i] = 0;
  endtask

  // Lines not marked full are a single hcount=0 cycle, which is all the row counter needs.
  task automatic run_frame(input int v1, input logic [NC-1:0] m1, input int v2,
                           input logic [NC-1:0] m2, input int rst_v, input int rst_h);
    bit mv;
    logic [NC-1:0] m;
    for (int v = 0; v < VTOT; v++) begin
      mv = 0; m = '0;
      if (v == v1) begin mv = 1; m = m1; end
      else if (v == v2) begin mv = 1; m = m2; end
      else if (rand_strobe && $urandom_range(0, 63) == 0) begin mv = 1; m = NC'($urandom()); end
      step(0, v, 0, mv, m);
      if (full_ln[v])
        for (int h = 1; h < HEND; h++) begin
          if (v == rst_v && h == rst_h) begin
            for (int k = 0; k < 3; k++) step(h, v, 1, 0, '0);
            return;
          end
          step(h, v, 0, 0, '0);
        end
    end
  endtask

  always @(negedge clk) begin
    oexp_t oe;
    aexp_t ae;
    if (oq.size() > 0 && oq[0].due <= cyc) begin
      oe = oq.pop_front();
      n_tests++;
      if (oe.due != cyc || rgb_out !== oe.rgb || hsync_out !== oe.hs ||
          vsync_out !== oe.vs || blank_out !== oe.bl) begin
        n_fail++;
        $display("FAIL pix(%0d,%0d) cyc %0d: got rgb=%h hs=%b vs=%b blank=%b, want rgb=%h hs=%b vs=%b blank=%b at cyc %0d",
                 oe.h, oe.v, cyc, rgb_out, hsync_out, vsync_out, blank_out,
                 oe.rgb, oe.hs, oe.vs, oe.bl, oe.due);
      end
    end
    if (aq.size() > 0 && aq[0].due <= cyc) begin
      ae = aq.pop_front();
      n_tests++;
      if (ae.due != cyc || fb_addr_out !== ae.addr) begin
        n_fail++;
        $display("FAIL addr(%0d,%0d) cyc %0d: got %0d, want %0d", ae.h, ae.v, cyc, fb_addr_out, ae.addr);
      end
    end
  end

  initial begin
    for (int k = 0; k < 5; k++) step($urandom_range(0, 799), $urandom_range(0, 524), 1, 0, '0);

    // F1: centre mask strobed mid-frame (last of two back-to-back strobes wins).
    clr_full();
    full_ln[2] = 1; full_ln[40] = 1; full_ln[80] = 1; full_ln[120] = 1;
    full_ln[239] = 1; full_ln[241] = 1;
    run_frame(99, 9'h1FF, 100, 9'h010, -1, -1);
    // F2: centre now on. F3: strobe on (0,0), still old mask. F4: new mask.
    clr_full();
    full_ln[40] = 1; full_ln[120] = 1; full_ln[160] = 1;
    run_frame(-1, '0, -1, '0, -1, -1);
    run_frame(0, 9'h004, -1, '0, -1, -1);
    run_frame(-1, '0, -1, '0, -1, -1);

    // F5: random strobes, reset in the middle of a grid line.
    rand_strobe = 1;
    clr_full();
    full_ln[$urandom_range(1, 119)] = 1; full_ln[120] = 1;
    run_frame(-1, '0, -1, '0, 120, 400);
    // F6: no mask survives the reset.
    rand_strobe = 0;
    clr_full();
    full_ln[40] = 1; full_ln[120] = 1;
    run_frame(-1, '0, -1, '0, -1, -1);

    rand_strobe = 1;
    for (int f = 0; f < 2; f++) begin
      clr_full();
      for (int k = 0; k < 4; k++) full_ln[$urandom_range(0, VTOT-1)] = 1;
      run_frame(-1, '0, -1, '0, -1, -1);
    end

    for (int k = 0; k < 20 && (oq.size() > 0 || aq.size() > 0); k++) @(negedge clk);
    n_tests++;
    if (oq.size() > 0 || aq.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d outputs still expected, want 0", oq.size() + aq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_debug_overlay.md
Name: camera_debug_overlay

Overview:
- Parametrised successor to the camera debug renderer.
- Draws a camera preview panel and a GRID_COLS x GRID_ROWS vision-cell panel on the display, on a single system clock.
- Reads a 12-bit framebuffer through an external synchronous read port with configurable latency.
- Latches vision masks so the display updates only at frame boundaries, which prevents tearing.
- Uses running counters instead of dividers to find the current cell.
- Can optionally draw grid lines between cells.

Parameters:
- FRAME_W, 320: preview width in pixels. The grid panel spans hcount FRAME_W..2*FRAME_W-1.
- FRAME_H, 240: preview and grid panel height.
- GRID_COLS, 3: number of cell columns.
- GRID_ROWS, 3: number of cell rows.
- MEM_LATENCY, 2: framebuffer read latency in cycles, from address to data. Minimum 1.
- COLOR_ON, 12'h00F: colour of a cell whose mask bit is 1.
- COLOR_OFF, 12'h000: colour of a cell whose mask bit is 0.
- COLOR_LINE, 12'h444: grid line colour.
- COLOR_BG, 12'hFFF: colour outside both panels.

Ports:
- system_clock_in  in  1  sole clock.
- reset_n_in  in  1  synchronous reset, active low.
- hcount_in  in  11  current pixel x.
- vcount_in  in  10  current pixel y.
- hsync_in  in  1  timing signal, pipelined through to hsync_out.
- vsync_in  in  1  timing signal, pipelined through to vsync_out.
- blank_in  in  1  timing signal, pipelined through to blank_out.
- grid_mask_in  in  GRID_COLS*GRID_ROWS  cell mask. Bit index is row*GRID_COLS+col.
- mask_valid_in  in  1  one-cycle strobe; qualifies grid_mask_in.
- show_grid_lines_in  in  1  enables grid-line drawing. Sampled per pixel.
- fb_addr_out  out  $clog2(FRAME_W*FRAME_H)  framebuffer read address.
- fb_data_in  in  12  framebuffer read data, arriving MEM_LATENCY cycles after the address.
- rgb_out  out  12  pixel colour.
- hsync_out, vsync_out, blank_out  out  1 each  timing outputs aligned with rgb_out.

Behaviour:
- Reset (reset_n_in low at a clock edge): rgb_out=0, hsync_out=0, vsync_out=0, blank_out=1, fb_addr_out=0. All pipeline stages, masks, the pending flag and the cell counters clear. The first valid output appears L cycles after release.
- Latency: L = MEM_LATENCY+1 cycles from hcount/vcount/sync inputs to rgb_out and the sync outputs. Every path, including grid and background pixels, uses the same delay.
- Address stage (registered): if hcount_in<FRAME_W and vcount_in<FRAME_H, fb_addr_out = vcount_in*FRAME_W + hcount_in. Otherwise fb_addr_out holds 0. Arithmetic is at least 20 bits wide, truncated to the port width.
- Mask capture:
  - mask_valid_in writes grid_mask_in into pending_mask and sets the pending flag.
  - At frame start (hcount_in==0 and vcount_in==0), if the pending flag is set, active_mask takes pending_mask and the flag clears.
  - Simultaneous mask_valid_in and frame start: active_mask takes the old pending value; the new mask stays pending until the next frame start.
  - Back-to-back strobes: the last one wins.
- Cell counters (stage 0, registered):
  - Column counter: col_pos/col_idx reset to 0 when hcount_in==FRAME_W. col_pos increments every pixel. At col_pos==CW-1 (CW=FRAME_W/GRID_COLS), it wraps and col_idx increments.
  - col_idx saturates at GRID_COLS-1, so remainder pixels belong to the last column.
  - Row counter: row_pos/row_idx use the same scheme with RH=FRAME_H/GRID_ROWS. They advance once per line when hcount_in==0 and vcount_in!=0, reset when vcount_in==0, and row_idx saturates at GRID_ROWS-1.
- Line flag: set when show_grid_lines_in=1 and the pixel is in the grid panel with col_pos==0 (col_idx!=0) or row_pos==0 (row_idx!=0).
- Pixel select, applied to stage-aligned signals at the final stage:
  - blank: 0.
  - Preview region: fb_data_in.
  - Grid region with line flag set: COLOR_LINE.
  - Grid region otherwise: active_mask[row_idx*GRID_COLS+col_idx] ? COLOR_ON : COLOR_OFF.
  - Anywhere else: COLOR_BG.
- Reset mid-frame: outputs return to reset values on the next edge. Counters resynchronise at the next hcount_in==FRAME_W and vcount_in==0. No stale mask survives reset.

Decomposition:
- camera_debug_pkg holds typedef logic [11:0] rgb12_t, the default colour constants, and a function for the cell-bit index.
- One sub-module, pipe_delay #(WIDTH, DEPTH): a synchronous-reset shift register. It carries the region, cell, line and sync signals for DEPTH stages (MEM_LATENCY).

Test Plan:
- Reset: hold reset_n_in low for 5 cycles while driving counts → rgb_out=0, blank_out=1, fb_addr_out=0. After release, the first non-reset rgb_out appears exactly L=3 cycles later (MEM_LATENCY=2).
- Preview: memory model returns addr[11:0] with 2-cycle latency; drive hcount=5, vcount=2 → fb_addr_out=645 one cycle later; rgb_out=12'h285 3 cycles after the input.
- Mask deferral:
  - Strobe mask 9'b000010000 mid-frame → centre cell (hcount=480, vcount=120) stays COLOR_OFF for the rest of that frame and shows 12'h00F after the next (0,0).
  - Strobe simultaneously with (0,0) → the change is deferred one more frame.
- Non-divisible grid: GRID_COLS=3 with FRAME_W=320 (CW=106) → hcount=FRAME_W+317..FRAME_W+319 map to col_idx=2. Bit 2 set → COLOR_ON there.
- Grid lines: show_grid_lines_in=1 → hcount=FRAME_W+106, any grid row, gives COLOR_LINE. hcount=FRAME_W+0 does not. With show_grid_lines_in=0, that pixel shows the cell colour.
- Background and blank: hcount=700 → 12'hFFF. Assert blank_in at a grid pixel → rgb_out=0 after L cycles, and blank_out aligned with it.
